// File: rtl/kmc_npr_pkg.sv
// rtl/kmc_npr_pkg.sv - shared constants and types for the KMC11 NPR sequencer
// Contents: NPRC bit indices, FSM state enum, default ack timeout.
package kmc_npr_pkg;

    // NPRC control register bit map
    localparam int NPRC_NRQ   = 0;  // go / busy
    localparam int NPRC_BYTE  = 1;  // byte transfer
    localparam int NPRC_IA_LO = 2;  // NPR in address bits 17:16
    localparam int NPRC_IA_HI = 3;
    localparam int NPRC_OUT   = 4;  // 1 = write to bus
    localparam int NPRC_OA_LO = 5;  // NPR out address bits 17:16
    localparam int NPRC_OA_HI = 6;
    localparam int NPRC_NXM   = 7;  // non-existent memory (ack timeout)

    // Bus cycles to wait for busACK before flagging NXM
    localparam int NPR_TIMEOUT = 63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } npr_state_e;

endpackage

// File: rtl/kmc_npr_ctrl_if.sv
// rtl/kmc_npr_ctrl_if.sv - device bus handshake between NPR sequencer and KS10 bus interface
// master: busREQ/busWR/busBYTE/busADDR/busDATAO out, busACK/busDATAI in (the sequencer)
// slave : the bus side, mirror image
interface kmc_npr_ctrl_if;
    logic        busREQ;
    logic        busWR;
    logic        busBYTE;
    logic [17:0] busADDR;
    logic [15:0] busDATAO;
    logic        busACK;
    logic [15:0] busDATAI;

    modport master (
        output busREQ, busWR, busBYTE, busADDR, busDATAO,
        input  busACK, busDATAI
    );

    modport slave (
        input  busREQ, busWR, busBYTE, busADDR, busDATAO,
        output busACK, busDATAI
    );
endinterface

// File: rtl/kmc_npr_timer.sv
// rtl/kmc_npr_timer.sv - 6-bit clear/enable counter with terminal-count flag
// Ports: clk, rst_n (async low), clr_i (sync clear, wins over en_i), en_i (count),
//        tc_o (high while the count is one short of LIMIT, i.e. the next enabled
//        cycle would reach LIMIT)
module kmc_npr_timer #(
    parameter int LIMIT = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 6'd0;
        else if (en_i)
            cnt_d = cnt_q + 6'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 6'd0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == 6'(LIMIT - 1));

endmodule

// File: rtl/kmc_npr_ctrl.sv
// rtl/kmc_npr_ctrl.sv - KMC11 NPR (DMA) sequencer: NPRC/NPRIA/NPROA/NPRID registers and bus FSM
// Ports: clk, rst_n (async low), kmcINIT (sync clear), kmcALU + write strobes
//        nprcWR/npriaLWR/npriaHWR/nproaLWR/nproaHWR, kmcNPROD (write data),
//        bus (kmc_npr_ctrl_if.master), kmcNPRC/kmcNPRIA/kmcNPROA/kmcNPRID register
//        views, kmcBUSY.
// Option: define KMC_NPR_AUTOINC_EN to step the active address after each transfer.
module kmc_npr_ctrl
    import kmc_npr_pkg::*;
#(
    parameter int TIMEOUT = NPR_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kmcINIT,
    input  logic [7:0]            kmcALU,
    input  logic                  nprcWR,
    input  logic                  npriaLWR,
    input  logic                  npriaHWR,
    input  logic                  nproaLWR,
    input  logic                  nproaHWR,
    input  logic [15:0]           kmcNPROD,
    kmc_npr_ctrl_if.master        bus,
    output logic [7:0]            kmcNPRC,
    output logic [15:0]           kmcNPRIA,
    output logic [15:0]           kmcNPROA,
    output logic [15:0]           kmcNPRID,
    output logic                  kmcBUSY
);

    npr_state_e  state_q, state_d;
    logic [7:0]  nprc_q, nprc_d;
    logic [15:0] npria_q, npria_d;
    logic [15:0] nproa_q, nproa_d;
    logic [15:0] nprid_q, nprid_d;
    logic        tmr_tc;

    // Counter is held clear outside REQ so every request starts from zero
    kmc_npr_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (kmcINIT || (state_q != REQ)),
        .en_i  (state_q == REQ),
        .tc_o  (tmr_tc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else if (kmcINIT)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state; ack beats a timeout on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (nprcWR && kmcALU[NPRC_NRQ]) state_d = REQ;
            REQ:     if (bus.busACK)                 state_d = DONE;
                     else if (tmr_tc)                state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busREQ  = 1'b0;
        bus.busWR   = 1'b0;
        bus.busBYTE = 1'b0;
        bus.busADDR = 18'd0;
        if (state_q == REQ) begin
            bus.busREQ  = 1'b1;
            bus.busWR   = nprc_q[NPRC_OUT];
            bus.busBYTE = nprc_q[NPRC_BYTE] & nprc_q[NPRC_OUT];
            bus.busADDR = nprc_q[NPRC_OUT] ? {nprc_q[NPRC_OA_HI:NPRC_OA_LO], nproa_q}
                                           : {nprc_q[NPRC_IA_HI:NPRC_IA_LO], npria_q};
        end
    end

    assign bus.busDATAO = kmcNPROD;
    assign kmcBUSY      = (state_q != IDLE);

`ifdef KMC_NPR_AUTOINC_EN
    logic [16:0] step;
    logic [16:0] ia_sum, oa_sum;
    assign step   = nprc_q[NPRC_BYTE] ? 17'd1 : 17'd2;
    assign ia_sum = {1'b0, npria_q} + step;
    assign oa_sum = {1'b0, nproa_q} + step;
`endif

    // Register file next state; microcode writes only land while idle
    always_comb begin
        nprc_d  = nprc_q;
        npria_d = npria_q;
        nproa_d = nproa_q;
        nprid_d = nprid_q;
        case (state_q)
            IDLE: begin
                if (nprcWR)   nprc_d        = kmcALU;
                if (npriaLWR) npria_d[7:0]  = kmcALU;
                if (npriaHWR) npria_d[15:8] = kmcALU;
                if (nproaLWR) nproa_d[7:0]  = kmcALU;
                if (nproaHWR) nproa_d[15:8] = kmcALU;
            end
            REQ: begin
                if (bus.busACK) begin
                    if (!nprc_q[NPRC_OUT]) nprid_d = bus.busDATAI;
                end else if (tmr_tc) begin
                    nprc_d[NPRC_NXM] = 1'b1;
                    nprc_d[NPRC_NRQ] = 1'b0;
                end
            end
            DONE: begin
                nprc_d[NPRC_NRQ] = 1'b0;
                nprc_d[NPRC_NXM] = 1'b0;
`ifdef KMC_NPR_AUTOINC_EN
                // Carry out of the 16-bit address bumps the 2-bit extension field
                if (nprc_q[NPRC_OUT]) begin
                    nproa_d = oa_sum[15:0];
                    if (oa_sum[16])
                        nprc_d[NPRC_OA_HI:NPRC_OA_LO] = nprc_q[NPRC_OA_HI:NPRC_OA_LO] + 2'd1;
                end else begin
                    npria_d = ia_sum[15:0];
                    if (ia_sum[16])
                        nprc_d[NPRC_IA_HI:NPRC_IA_LO] = nprc_q[NPRC_IA_HI:NPRC_IA_LO] + 2'd1;
                end
`else
                // Addresses change only by microcode writes
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nprc_q  <= 8'd0;
            npria_q <= 16'd0;
            nproa_q <= 16'd0;
            nprid_q <= 16'd0;
        end else if (kmcINIT) begin
            nprc_q  <= 8'd0;
            npria_q <= 16'd0;
            nproa_q <= 16'd0;
            nprid_q <= 16'd0;
        end else begin
            nprc_q  <= nprc_d;
            npria_q <= npria_d;
            nproa_q <= nproa_d;
            nprid_q <= nprid_d;
        end
    end

    assign kmcNPRC  = nprc_q;
    assign kmcNPRIA = npria_q;
    assign kmcNPROA = nproa_q;
    assign kmcNPRID = nprid_q;

endmodule

// File: tb/tb_kmc_npr_ctrl.sv
// tb/tb_kmc_npr_ctrl.sv - scoreboard testbench for kmc_npr_ctrl
module tb_kmc_npr_ctrl;

`ifdef KMC_NPR_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic        bbyte;
        logic [17:0] addr;
        logic [15:0] dato;
    } req_exp_t;

    typedef struct {
        logic [7:0]  nprc;
        logic [15:0] nprid;
        logic [15:0] npria;
        logic [15:0] nproa;
        int          reqs;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kmcINIT = 1'b0;
    logic [7:0]  kmcALU = 8'd0;
    logic        nprcWR = 1'b0, npriaLWR = 1'b0, npriaHWR = 1'b0;
    logic        nproaLWR = 1'b0, nproaHWR = 1'b0;
    logic [15:0] kmcNPROD = 16'd0;
    logic [7:0]  kmcNPRC;
    logic [15:0] kmcNPRIA, kmcNPROA, kmcNPRID;
    logic        kmcBUSY;
    logic        snap = 1'b0;

    kmc_npr_ctrl_if bus ();

    kmc_npr_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .kmcINIT  (kmcINIT),
        .kmcALU   (kmcALU),
        .nprcWR   (nprcWR),
        .npriaLWR (npriaLWR),
        .npriaHWR (npriaHWR),
        .nproaLWR (nproaLWR),
        .nproaHWR (nproaHWR),
        .kmcNPROD (kmcNPROD),
        .bus      (bus.master),
        .kmcNPRC  (kmcNPRC),
        .kmcNPRIA (kmcNPRIA),
        .kmcNPROA (kmcNPROA),
        .kmcNPRID (kmcNPRID),
        .kmcBUSY  (kmcBUSY)
    );

    always #5 clk = ~clk;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    int   req_cnt = 0;
    logic prev_req = 1'b0, prev_busy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.busREQ === 1'b1) req_cnt++;
        if (bus.busREQ === 1'b1 && !prev_req) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                req_exp_t r;
                r = req_q.pop_front();
                chk("busWR",    {31'd0, bus.busWR},   {31'd0, r.wr});
                chk("busBYTE",  {31'd0, bus.busBYTE}, {31'd0, r.bbyte});
                chk("busADDR",  {14'd0, bus.busADDR}, {14'd0, r.addr});
                chk("busDATAO", {16'd0, bus.busDATAO}, {16'd0, r.dato});
            end
        end
        if ((prev_busy && kmcBUSY === 1'b0) || snap) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                chk("NPRC",     {24'd0, kmcNPRC},  {24'd0, d.nprc});
                chk("NPRID",    {16'd0, kmcNPRID}, {16'd0, d.nprid});
                chk("NPRIA",    {16'd0, kmcNPRIA}, {16'd0, d.npria});
                chk("NPROA",    {16'd0, kmcNPROA}, {16'd0, d.nproa});
                chk("req_cycles", req_cnt, d.reqs);
                chk("busREQ_idle", {31'd0, bus.busREQ}, 32'd0);
            end
            req_cnt = 0;
        end
        prev_req  = bus.busREQ;
        prev_busy = kmcBUSY;
    end

    // strb bits: {nproaH, nproaL, npriaH, npriaL, nprc}
    task automatic wr(input logic [4:0] strb, input logic [7:0] v);
        kmcALU   = v;
        nprcWR   = strb[0];
        npriaLWR = strb[1];
        npriaHWR = strb[2];
        nproaLWR = strb[3];
        nproaHWR = strb[4];
        @(negedge clk);
        nprcWR = 0; npriaLWR = 0; npriaHWR = 0; nproaLWR = 0; nproaHWR = 0;
        kmcALU = 8'd0;
    endtask

    task automatic push_req(input logic w, input logic b, input logic [17:0] a, input logic [15:0] o);
        req_exp_t r;
        r.wr = w; r.bbyte = b; r.addr = a; r.dato = o;
        req_q.push_back(r);
    endtask

    task automatic push_done(input logic [7:0] c, input logic [15:0] id, input logic [15:0] ia,
                             input logic [15:0] oa, input int n);
        done_exp_t d;
        d.nprc = c; d.nprid = id; d.npria = ia; d.nproa = oa; d.reqs = n;
        done_q.push_back(d);
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.busREQ !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busREQ !== 1'b1) chk("wait_busREQ_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (kmcBUSY !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (kmcBUSY !== 1'b0) chk("wait_idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic ack_after(input int w, input logic [15:0] data);
        wait_req();
        repeat (w) @(negedge clk);
        bus.busACK   = 1'b1;
        bus.busDATAI = data;
        @(negedge clk);
        bus.busACK   = 1'b0;
        bus.busDATAI = 16'd0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    initial begin
        bus.busACK   = 1'b0;
        bus.busDATAI = 16'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        push_done(8'h00, 16'h0000, 16'h0000, 16'h0000, 0);
        do_snap();

        // Word read from 0o001000, ack after 3 wait cycles
        wr(5'b00010, 8'h00);
        wr(5'b00100, 8'h02);
        push_req(1'b0, 1'b0, 18'o001000, 16'h0000);
        push_done(8'h00, 16'hBEEF, AI ? 16'h0202 : 16'h0200, 16'h0000, 4);
        wr(5'b00001, 8'h01);
        ack_after(3, 16'hBEEF);
        wait_idle();

        // Byte write to 0o002001
        kmcNPROD = 16'h00AA;
        wr(5'b01000, 8'h01);
        wr(5'b10000, 8'h04);
        push_req(1'b1, 1'b1, 18'o002001, 16'h00AA);
        push_done(8'h12, 16'hBEEF, AI ? 16'h0202 : 16'h0200, AI ? 16'h0402 : 16'h0401, 1);
        wr(5'b00001, 8'h13);
        ack_after(0, 16'h0000);
        wait_idle();

        // Timeout: no ack, 63 request cycles then NXM
        push_req(1'b0, 1'b0, AI ? 18'h00202 : 18'h00200, 16'h00AA);
        push_done(8'h80, 16'hBEEF, AI ? 16'h0202 : 16'h0200, AI ? 16'h0402 : 16'h0401, 63);
        wr(5'b00001, 8'h01);
        wait_idle();

        // Address wrap with extension field 3
        wr(5'b00010, 8'hFE);
        wr(5'b00100, 8'hFF);
        push_req(1'b0, 1'b0, 18'h3FFFE, 16'h00AA);
        push_done(AI ? 8'h00 : 8'h0C, 16'h1234, AI ? 16'h0000 : 16'hFFFE,
                  AI ? 16'h0402 : 16'h0401, 2);
        wr(5'b00001, 8'h0D);
        ack_after(1, 16'h1234);
        wait_idle();

        // Same-cycle low/high strobe, then writes while busy are ignored
        wr(5'b00110, 8'h11);
        push_req(1'b0, 1'b0, 18'h01111, 16'h00AA);
        push_done(8'h00, 16'h5A5A, AI ? 16'h1113 : 16'h1111, AI ? 16'h0402 : 16'h0401, 2);
        wr(5'b00001, 8'h01);
        wait_req();
        wr(5'b00011, 8'h00);
        bus.busACK   = 1'b1;
        bus.busDATAI = 16'h5A5A;
        @(negedge clk);
        bus.busACK   = 1'b0;
        bus.busDATAI = 16'h0000;
        wait_idle();

        // Byte write at 0x1FFFF: carry into the OUT extension field
        kmcNPROD = 16'h1357;
        wr(5'b11000, 8'hFF);
        push_req(1'b1, 1'b1, 18'h1FFFF, 16'h1357);
        push_done(AI ? 8'h52 : 8'h32, 16'h5A5A, AI ? 16'h1113 : 16'h1111,
                  AI ? 16'h0000 : 16'hFFFF, 3);
        wr(5'b00001, 8'h33);
        ack_after(2, 16'h0000);
        wait_idle();

        // rst_n mid-request, then a stray ack
        kmcNPROD = 16'h0000;
        push_req(1'b0, 1'b0, AI ? 18'h01113 : 18'h01111, 16'h0000);
        push_done(8'h00, 16'h0000, 16'h0000, 16'h0000, 3);
        wr(5'b00001, 8'h01);
        wait_req();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.busACK   = 1'b1;
        bus.busDATAI = 16'hDEAD;
        @(negedge clk);
        bus.busACK   = 1'b0;
        bus.busDATAI = 16'h0000;
        push_done(8'h00, 16'h0000, 16'h0000, 16'h0000, 0);
        do_snap();

        // kmcINIT mid-request
        push_req(1'b0, 1'b0, 18'h00000, 16'h0000);
        push_done(8'h00, 16'h0000, 16'h0000, 16'h0000, 1);
        wr(5'b00001, 8'h01);
        wait_req();
        kmcINIT = 1'b1;
        @(negedge clk);
        kmcINIT = 1'b0;
        @(negedge clk);

        // Normal transfer after kmcINIT
        push_req(1'b0, 1'b0, 18'h00000, 16'h0000);
        push_done(8'h00, 16'h7777, AI ? 16'h0002 : 16'h0000, 16'h0000, 1);
        wr(5'b00001, 8'h01);
        ack_after(0, 16'h7777);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("req_queue_drained",  req_q.size(),  0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
